mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed 4096 x 32 memory responder serving the CPU core's two memory clients: the instruction fetch port (read-only) and the load/store data port. Each cycle it accepts at most one request and arbitrates between ports, with data priority and bounded fetch starvation. It returns read data or a write acknowledge exactly one cycle after the grant. It is the responding end of the CPU's `lw`/`sw` and fetch traffic.

## Interface
- `DEPTH`, 4096: number of 32-bit words.
- `ADDR_W`, 12: index width, log2(DEPTH).
- `STARVE_MAX`, 3: maximum consecutive data grants allowed while a fetch is pending.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch word address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: fetch response valid.
- `if_rdata` out 32: fetch data.
- `if_err` out 1: fetch address out of range; qualified by `if_rvalid`.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data word address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: load data valid, or store acknowledge.
- `d_rdata` out 32: load data; 0 for stores.
- `d_err` out 1: data address out of range; qualified by `d_rvalid`.

## Operation
- **Request holding:** a request is held, with address, we and wdata stable, until its `*_gnt` is seen high. Grants are combinational from the current `*_req` and the arbiter state.
- **Arbitration:**
  - Only `d_req`: grant data. Only `if_req`: grant fetch.
  - Both requesting: grant data unless `starve_cnt == STARVE_MAX`, in which case grant fetch.
  - `starve_cnt` increments on each data grant while `if_req` is high, saturating at `STARVE_MAX`. It clears on any fetch grant, or on any cycle with `if_req` low.
- **Range check:** address is in range iff `addr[31:ADDR_W] == 0`.
- **Out-of-range request:**
  - No array access and no write.
  - Response has `rdata = 0` and `err = 1`.
  - A granted request always gets a response.
- **Load / fetch:** `rdata = mem[addr[ADDR_W-1:0]]`. The array value is sampled at the grant edge.
- **Store:**
  - Writes `d_wdata` at the grant edge.
  - `d_rvalid` pulses next cycle with `d_rdata = 0`.
  - A fetch to the same address granted later sees the new value.
- **Same-cycle access:** only one port is granted per cycle, so there is no same-cycle read/write collision.
- **Memory contents:** not reset; X until written. The bench preloads via hierarchical write or `$readmemh` into the array.

## Timing
- **Latency:** grant in cycle N -> `*_rvalid` high for exactly cycle N+1, with registered `rdata` and `err`.
- **Throughput:** one grant per cycle total. Back-to-back grants to the same port are allowed; responses then pulse on consecutive cycles.
- **Reset values:** while `rst_n` is low, `if_rvalid`, `d_rvalid`, `if_err`, `d_err` = 0, `if_rdata`, `d_rdata` = 0, `starve_cnt` = 0. Grants are forced 0 during reset.
- **Reset mid-operation:** a response pending for cycle N+1 is dropped and never emitted. A store granted at the edge where reset asserts asynchronously does not occur. Array contents already written are retained.
- **Response timing:** `rvalid` outputs have no dependence on the requester's state; responses are never back-pressured.
- **Starvation bound:** with both requests held continuously, the grant pattern is D,D,D,F,D,D,D,F,…

## Structure
- Shared `mem_pkg` holds:
  - `MEM_DEPTH = 4096` and `MEM_ADDR_W = 12`.
  - Opcode constants `OP_LW = 6'h23`, `OP_SW = 6'h2B` for the CPU-side request generation.
  - A `mem_req_t` struct: `req`, `we`, `addr[31:0]`, `wdata[31:0]`.
- Sub-module `mem_arbiter`: two-port priority arbiter with the starvation counter; outputs the two grants and the selected port. The array, range check and response registers stay in `mem_responder`.

## Test plan
- **Reset:** assert `rst_n = 0` mid-run with a fetch granted the previous cycle -> no `if_rvalid`, all outputs 0, `starve_cnt = 0`.
- **Store then fetch:** store `0xDEADBEEF` to addr 5; cycle after grant `d_rvalid = 1`, `d_rdata = 0`. Then fetch addr 5 -> `if_rvalid` one cycle after `if_gnt` with `if_rdata = 0xDEADBEEF`.
- **Contention:** both `if_req` and `d_req` held for 8 cycles -> grants D,D,D,F,D,D,D,F. Every response arrives exactly one cycle after its grant.
- **Out of range:** load addr `0x00001000` -> `d_rvalid = 1`, `d_err = 1`, `d_rdata = 0`. Then store to `0x00001003` -> `d_err = 1`, and a read of addr 3 is unchanged.
- **Back-to-back loads:** preload addr 0..3 with 10..13; loads to 0,1,2,3 on consecutive cycles with no fetch -> `d_rdata` = 10,11,12,13 on consecutive cycles.
- **Fetch-only streaming:** fetch addrs 0..4 with `d_req = 0` -> a grant every cycle and `starve_cnt` stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-side constants and the request bundle used by the responder.
// Opcodes identify the CPU instructions that generate data-port traffic.
package mem_pkg;

    localparam int MEM_DEPTH  = 4096;
    localparam int MEM_ADDR_W = 12;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter: data wins, but fetch is granted after STARVE_MAX consecutive data wins.
// Grants are combinational, gated off while reset is asserted.
module mem_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt,
    output logic sel_d
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             fetch_turn;

    always_comb begin
        fetch_turn   = (starve_cnt_q == CNT_W'(STARVE_MAX));
        d_gnt        = rst_n & d_req & ~(if_req & fetch_turn);
        if_gnt       = rst_n & if_req & (~d_req | fetch_turn);
        sel_d        = d_gnt;
        starve_cnt_d = starve_cnt_q;
        // Count only data wins that actually kept a fetch waiting.
        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && !fetch_turn) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory serving fetch and load/store ports; one grant per cycle.
// Response one cycle after grant; responses are never back-pressured.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH      = MEM_DEPTH,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err
);

    logic [31:0] mem_q [DEPTH];

    mem_req_t          if_r;
    mem_req_t          d_r;
    mem_req_t          sel_r;
    logic              sel_d;
    logic              in_range;
    logic              rd_ok;
    logic              wr_en;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_dat;

    logic        if_rvalid_q, if_rvalid_d;
    logic        if_err_q,    if_err_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic        d_rvalid_q,  d_rvalid_d;
    logic        d_err_q,     d_err_d;
    logic [31:0] d_rdata_q,   d_rdata_d;

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt),
        .sel_d  (sel_d)
    );

    always_comb begin
        if_r     = '{req: if_req, we: 1'b0, addr: if_addr, wdata: 32'h0};
        d_r      = '{req: d_req, we: d_we, addr: d_addr, wdata: d_wdata};
        sel_r    = sel_d ? d_r : if_r;
        in_range = (sel_r.addr[31:ADDR_W] == '0);
        idx      = sel_r.addr[ADDR_W-1:0];
        rd_dat   = mem_q[idx];
        rd_ok    = sel_r.req & in_range;
        wr_en    = d_gnt & rd_ok & sel_r.we;
    end

    // Out-of-range requests still respond, with err set and zero data.
    always_comb begin
        if_rvalid_d = if_gnt;
        if_err_d    = if_gnt & ~in_range;
        if_rdata_d  = (if_gnt & rd_ok) ? rd_dat : 32'h0;
        d_rvalid_d  = d_gnt;
        d_err_d     = d_gnt & ~in_range;
        d_rdata_d   = (d_gnt & rd_ok & ~sel_r.we) ? rd_dat : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'h0;
        end else begin
            if_rvalid_q <= if_rvalid_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Array is not reset; wr_en is already gated off while reset is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= sel_r.wdata;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized checks of mem_responder against a queue-free array/streak model.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0] if_rdata, d_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_mem [MEM_DEPTH];
    int          m_streak;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_rvalid"}, {31'h0, if_rvalid}, 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_if_err"}, {31'h0, if_err}, 32'h0);
        chk({tag, "_d_rvalid"}, {31'h0, d_rvalid}, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk({tag, "_d_err"}, {31'h0, d_err}, 32'h0);
        chk({tag, "_if_gnt"}, {31'h0, if_gnt}, 32'h0);
        chk({tag, "_d_gnt"}, {31'h0, d_gnt}, 32'h0);
        chk({tag, "_starve"}, 32'(dut.u_arb.starve_cnt_q), 32'h0);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input string tag,
                        input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dd,
                        output logic obs_gi, output logic obs_gd);
        logic        egi, egd, ok;
        logic [31:0] e_if_dat, e_d_dat;
        logic        e_if_err, e_d_err;
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
        egd = dr && !(ir && m_streak == SMAX);
        egi = ir && !egd;
        chk({tag, "_if_gnt"}, {31'h0, if_gnt}, {31'h0, egi});
        chk({tag, "_d_gnt"}, {31'h0, d_gnt}, {31'h0, egd});
        obs_gi = if_gnt;
        obs_gd = d_gnt;
        e_if_dat = 32'h0; e_if_err = 1'b0; e_d_dat = 32'h0; e_d_err = 1'b0;
        if (egi) begin
            ok       = (ia >> MEM_ADDR_W) == 0;
            e_if_err = !ok;
            e_if_dat = ok ? m_mem[ia % MEM_DEPTH] : 32'h0;
        end
        if (egd) begin
            ok      = (da >> MEM_ADDR_W) == 0;
            e_d_err = !ok;
            if (ok && !dw) e_d_dat = m_mem[da % MEM_DEPTH];
            if (ok && dw)  m_mem[da % MEM_DEPTH] = dd;
        end
        if (!ir || egi)                      m_streak = 0;
        else if (egd && m_streak < SMAX)     m_streak = m_streak + 1;
        @(posedge clk);
        #1;
        chk({tag, "_if_rvalid"}, {31'h0, if_rvalid}, {31'h0, egi});
        chk({tag, "_d_rvalid"}, {31'h0, d_rvalid}, {31'h0, egd});
        if (egi) begin
            chk({tag, "_if_rdata"}, if_rdata, e_if_dat);
            chk({tag, "_if_err"}, {31'h0, if_err}, {31'h0, e_if_err});
        end
        if (egd) begin
            chk({tag, "_d_rdata"}, d_rdata, e_d_dat);
            chk({tag, "_d_err"}, {31'h0, d_err}, {31'h0, e_d_err});
        end
        chk({tag, "_starve"}, 32'(dut.u_arb.starve_cnt_q), 32'(m_streak));
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_addr();
        if ($urandom_range(0, 7) == 0)
            return (32'h1 << $urandom_range(12, 31)) | 32'($urandom_range(0, 4095));
        return 32'($urandom_range(0, 15));
    endfunction

    logic        gi, gd;
    logic [7:0]  pat;
    logic [31:0] v;
    logic        cur_ir, cur_dr, cur_dw;
    logic [31:0] cur_ia, cur_da, cur_dd;
    logic [5:0]  op;

    initial begin
        rst_n = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        m_streak = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            v = $urandom;
            dut.mem_q[i] = v;
            m_mem[i] = v;
        end
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Store then fetch the same word.
        step("st5", 1'b0, 32'h0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF, gi, gd);
        step("if5", 1'b1, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
        chk("if5_value", if_rdata, 32'hDEADBEEF);

        // Contention: both ports held for 8 cycles.
        pat = 8'b1110_1110;
        for (int i = 0; i < 8; i++) begin
            step("cont", 1'b1, 32'(i), 1'b1, 1'b0, 32'(i + 8), 32'h0, gi, gd);
            chk("cont_pattern", {31'h0, gd}, {31'h0, pat[7-i]});
        end

        // Out of range load and store; word 3 must survive.
        step("oor_ld", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, gi, gd);
        chk("oor_ld_err", {31'h0, d_err}, 32'h1);
        step("oor_st", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1003, 32'h1234_5678, gi, gd);
        chk("oor_st_err", {31'h0, d_err}, 32'h1);
        step("rd3", 1'b0, 32'h0, 1'b1, 1'b0, 32'd3, 32'h0, gi, gd);

        // Back-to-back loads of preloaded words.
        for (int i = 0; i < 4; i++) begin
            dut.mem_q[i] = 32'(10 + i);
            m_mem[i] = 32'(10 + i);
        end
        for (int i = 0; i < 4; i++) begin
            step("b2b", 1'b0, 32'h0, 1'b1, 1'b0, 32'(i), 32'h0, gi, gd);
            chk("b2b_value", d_rdata, 32'(10 + i));
        end

        // Fetch-only stream.
        for (int i = 0; i < 5; i++) begin
            step("ifstream", 1'b1, 32'(i), 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
            chk("ifstream_gnt", {31'h0, gi}, 32'h1);
        end

        // Reset right after a fetch grant: its response must be dropped.
        if_req = 1'b1; if_addr = 32'd7; d_req = 1'b0;
        #1;
        chk("rst_a_gnt", {31'h0, if_gnt}, 32'h1);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_a");
        @(negedge clk);
        chk_all_zero("rst_a_late");
        if_req = 1'b0;
        rst_n = 1'b1;
        m_streak = 0;

        // Build a starvation streak, then reset during a store grant.
        step("pre", 1'b1, 32'd1, 1'b1, 1'b0, 32'd2, 32'h0, gi, gd);
        step("pre", 1'b1, 32'd1, 1'b1, 1'b0, 32'd2, 32'h0, gi, gd);
        chk("pre_streak", 32'(dut.u_arb.starve_cnt_q), 32'd2);
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'd9; d_wdata = 32'hCAFE_F00D;
        #1;
        chk("rst_b_gnt", {31'h0, d_gnt}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_b");
        @(posedge clk);
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b1;
        m_streak = 0;
        step("rd9", 1'b0, 32'h0, 1'b1, 1'b0, 32'd9, 32'h0, gi, gd);

        // Randomized traffic; requests held until granted.
        cur_ir = 1'b0; cur_dr = 1'b0; cur_dw = 1'b0;
        cur_ia = 32'h0; cur_da = 32'h0; cur_dd = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!cur_ir) begin
                cur_ir = ($urandom_range(0, 3) != 0);
                cur_ia = gen_addr();
            end
            if (!cur_dr) begin
                cur_dr = ($urandom_range(0, 3) != 0);
                op     = ($urandom_range(0, 1) != 0) ? OP_SW : OP_LW;
                cur_dw = (op == OP_SW);
                cur_da = gen_addr();
                cur_dd = $urandom;
            end
            step("rand", cur_ir, cur_ia, cur_dr, cur_dw, cur_da, cur_dd, gi, gd);
            if (gi) cur_ir = 1'b0;
            if (gd) cur_dr = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
